// File: rtl/watch_dp.sv
// Timekeeping datapath: 1/100 s time base feeding cascaded centisecond,
// second, minute and hour counters, with single-step adjust inputs.
module watch_dp #(
  parameter int unsigned TICK_DIV  = 1_000_000,
  parameter int unsigned INIT_HOUR = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run_sec,
  input  logic       i_run_min,
  input  logic       i_run_hour,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_sec_tick
);

  localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MSEC_W  = 7;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned SEC_SW  = SEC_W + 1;
  localparam int unsigned MIN_SW  = MIN_W + 1;
  localparam int unsigned HOUR_SW = HOUR_W + 1;

  logic [CNT_W-1:0]  cnt_q;
  logic              tick_c;
  logic              c_msec_c;
  logic              c_sec_c;
  logic              c_min_c;
  logic [MSEC_W-1:0] msec_next_c;
  logic [SEC_SW-1:0] sec_sum_c;
  logic [MIN_SW-1:0] min_sum_c;
  logic [HOUR_SW-1:0] hour_sum_c;
  logic [SEC_W-1:0]  sec_next_c;
  logic [MIN_W-1:0]  min_next_c;
  logic [HOUR_W-1:0] hour_next_c;

  // Free-running time base; adjust pulses never touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Natural carries depend only on pre-update field values.
  always_comb begin
    tick_c   = (cnt_q == CNT_W'(TICK_DIV - 1));
    c_msec_c = tick_c && (o_msec == MSEC_W'(99));
    c_sec_c  = c_msec_c && (o_sec == SEC_W'(59));
    c_min_c  = c_sec_c && (o_min == MIN_W'(59));
  end

  // Field sums carry one extra bit; max sum is N+1 so one subtract suffices.
  always_comb begin
    msec_next_c = o_msec;
    if (tick_c) begin
      msec_next_c = (o_msec == MSEC_W'(99)) ? '0 : o_msec + MSEC_W'(1);
    end

    sec_sum_c  = {1'b0, o_sec} + SEC_SW'(c_msec_c) + SEC_SW'(i_run_sec);
    min_sum_c  = {1'b0, o_min} + MIN_SW'(c_sec_c) + MIN_SW'(i_run_min);
    hour_sum_c = {1'b0, o_hour} + HOUR_SW'(c_min_c) + HOUR_SW'(i_run_hour);

    sec_next_c  = (sec_sum_c >= SEC_SW'(60)) ? SEC_W'(sec_sum_c - SEC_SW'(60))
                                             : SEC_W'(sec_sum_c);
    min_next_c  = (min_sum_c >= MIN_SW'(60)) ? MIN_W'(min_sum_c - MIN_SW'(60))
                                             : MIN_W'(min_sum_c);
    hour_next_c = (hour_sum_c >= HOUR_SW'(24)) ? HOUR_W'(hour_sum_c - HOUR_SW'(24))
                                               : HOUR_W'(hour_sum_c);
  end

  // All time fields update together on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_msec     <= '0;
      o_sec      <= '0;
      o_min      <= '0;
      o_hour     <= HOUR_W'(INIT_HOUR);
      o_sec_tick <= 1'b0;
    end else begin
      o_msec     <= msec_next_c;
      o_sec      <= sec_next_c;
      o_min      <= min_next_c;
      o_hour     <= hour_next_c;
      o_sec_tick <= c_msec_c;
    end
  end

endmodule

// File: tb/tb_watch_dp.sv
// Bench for watch_dp: time-arithmetic model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_watch_dp;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_run_sec = 1'b0;
  logic       i_run_min = 1'b0;
  logic       i_run_hour = 1'b0;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_sec_tick;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;

  watch_dp #(.TICK_DIV(TD), .INIT_HOUR(12)) dut (
    .clk(clk), .rst(rst),
    .i_run_sec(i_run_sec), .i_run_min(i_run_min), .i_run_hour(i_run_hour),
    .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_sec_tick(o_sec_tick)
  );

  always #5 clk = ~clk;

  // Model: cycles since reset give the tick phase; fields are plain integers.
  int m_cyc, m_msec, m_sec, m_min, m_hour;
  bit m_tick;
  bit mt, mc_ms, mc_s, mc_m;
  assign mt    = (m_cyc % TD) == TD - 1;
  assign mc_ms = mt && (m_msec == 99);
  assign mc_s  = mc_ms && (m_sec == 59);
  assign mc_m  = mc_s && (m_min == 59);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 0; m_msec <= 0; m_sec <= 0; m_min <= 0; m_hour <= 12; m_tick <= 1'b0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_msec <= mt ? (m_msec + 1) % 100 : m_msec;
      m_sec  <= (m_sec + int'(mc_ms) + int'(i_run_sec)) % 60;
      m_min  <= (m_min + int'(mc_s) + int'(i_run_min)) % 60;
      m_hour <= (m_hour + int'(mc_m) + int'(i_run_hour)) % 24;
      m_tick <= mc_ms;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("msec", int'(o_msec), m_msec);
    check("sec", int'(o_sec), m_sec);
    check("min", int'(o_min), m_min);
    check("hour", int'(o_hour), m_hour);
    check("sec_tick", int'(o_sec_tick), int'(m_tick));
    if (o_sec_tick === 1'b1) tick_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int field(input int f);
    return (f == 0) ? m_sec : (f == 1) ? m_min : m_hour;
  endfunction

  // Pulse one adjust input, one cycle at a time, until the field hits target.
  task automatic pulse_until(input int f, input int target);
    int n = 0;
    while (field(f) != target && n < 200) begin
      i_run_sec = (f == 0); i_run_min = (f == 1); i_run_hour = (f == 2);
      step();
      i_run_sec = 1'b0; i_run_min = 1'b0; i_run_hour = 1'b0;
      n++;
    end
    if (field(f) != target) check("pulse_timeout", field(f), target);
  endtask

  // Advance until the current cycle is a tick cycle with msec at the target.
  task automatic wait_tick_at(input int ms);
    int n = 0;
    while (!(m_msec == ms && (m_cyc % TD) == TD - 1) && n < 1000) begin
      step();
      n++;
    end
    if (!(m_msec == ms && (m_cyc % TD) == TD - 1)) check("wait_timeout", m_msec, ms);
  endtask

  initial begin
    int ms0;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_msec", int'(o_msec), 0);
    check("rst_hour", int'(o_hour), 12);
    check("rst_sec_tick", int'(o_sec_tick), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // 100 ticks: msec wraps and seconds advance once.
    repeat (TD * 100) step();
    check("run_msec", int'(o_msec), 0);
    check("run_sec", int'(o_sec), 1);
    check("run_min", int'(o_min), 0);
    check("run_hour", int'(o_hour), 12);
    check("run_sec_tick", int'(o_sec_tick), 1);
    repeat (2) step();
    check("run_tick_count", tick_seen, 1);

    // Natural carry plus adjust on seconds in the same cycle.
    pulse_until(0, 59);
    wait_tick_at(99);
    i_run_sec = 1'b1;
    step();
    i_run_sec = 1'b0;
    check("dbl_sec", int'(o_sec), 1);
    check("dbl_min", int'(o_min), 1);
    check("dbl_msec", int'(o_msec), 0);
    check("dbl_sec_tick", int'(o_sec_tick), 1);

    // Minute adjust wraps without carrying into hours.
    pulse_until(1, 59);
    check("adj_min59", int'(o_min), 59);
    i_run_min = 1'b1;
    step();
    i_run_min = 1'b0;
    check("adj_min_wrap", int'(o_min), 0);
    check("adj_hour", int'(o_hour), 12);
    check("adj_sec_tick", int'(o_sec_tick), 0);

    // Full-day rollover from 23:59:59.99.
    pulse_until(2, 23);
    pulse_until(1, 59);
    pulse_until(0, 59);
    wait_tick_at(99);
    step();
    check("day_hour", int'(o_hour), 0);
    check("day_min", int'(o_min), 0);
    check("day_sec", int'(o_sec), 0);
    check("day_msec", int'(o_msec), 0);
    check("day_sec_tick", int'(o_sec_tick), 1);

    // Async reset mid-cycle from 05:30:45.50.
    pulse_until(2, 5);
    pulse_until(1, 30);
    pulse_until(0, 45);
    n = 0;
    while (m_msec != 50 && n < 1000) begin step(); n++; end
    check("pre_rst_hour", int'(o_hour), 5);
    check("pre_rst_min", int'(o_min), 30);
    check("pre_rst_sec", int'(o_sec), 45);
    check("pre_rst_msec", int'(o_msec), 50);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_hour", int'(o_hour), 12);
    check("arst_min", int'(o_min), 0);
    check("arst_sec", int'(o_sec), 0);
    check("arst_msec", int'(o_msec), 0);
    repeat (2) step();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (TD - 1) step();
    check("post_rst_no_tick", int'(o_msec), 0);
    step();
    check("post_rst_first_tick", int'(o_msec), 1);

    // Concurrent adjust from 12:10:20; tick grid is preserved.
    pulse_until(1, 10);
    pulse_until(0, 20);
    n = 0;
    while ((m_cyc % TD) != 0 && n < 10) begin step(); n++; end
    ms0 = m_msec;
    i_run_sec = 1'b1; i_run_min = 1'b1; i_run_hour = 1'b1;
    step();
    i_run_sec = 1'b0; i_run_min = 1'b0; i_run_hour = 1'b0;
    check("all_hour", int'(o_hour), 13);
    check("all_min", int'(o_min), 11);
    check("all_sec", int'(o_sec), 21);
    check("all_msec", int'(o_msec), ms0);
    repeat (TD - 2) step();
    check("grid_hold", int'(o_msec), ms0);
    step();
    check("grid_tick", int'(o_msec), (ms0 + 1) % 100);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_dp.md
Name: watch_dp

Overview:
- Timekeeping datapath driven by the watch control unit.
- Runs a free-running 1/100 s time base and cascaded centisecond/second/minute/hour counters.
- Consumes the control unit's single-cycle adjust pulses (sec/min/hour) to step individual fields.
- Outputs feed the FND/UART display formatting logic.

Parameters:
- TICK_DIV, 1_000_000: clk cycles per 1/100 s tick (100 MHz clk); minimum 2.
- INIT_HOUR, 12: hour value loaded on reset (0..23).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- i_run_sec  input  1  single-cycle pulse: step seconds by +1
- i_run_min  input  1  single-cycle pulse: step minutes by +1
- i_run_hour  input  1  single-cycle pulse: step hours by +1
- o_msec  output  7  centiseconds, 0..99
- o_sec  output  6  seconds, 0..59
- o_min  output  6  minutes, 0..59
- o_hour  output  5  hours, 0..23
- o_sec_tick  output  1  one-cycle pulse when seconds advance by natural carry

Behaviour:
- Clock clk; reset rst, asynchronous, active-high.
- Reset values:
  - tick counter = 0
  - o_msec = 0, o_sec = 0, o_min = 0
  - o_hour = INIT_HOUR
  - o_sec_tick = 0
- Time base:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 combinationally when counter == TICK_DIV-1.
  - First tick occurs in cycle TICK_DIV after reset release.
- Natural carry chain, evaluated in the same cycle as tick:
  - c_msec = tick && msec==99
  - c_sec = c_msec && sec==59
  - c_min = c_sec && min==59
- Field update per cycle; all fields registered, all update on the same edge:
  - msec_next = tick ? (msec==99 ? 0 : msec+1) : msec
  - sec_next = (sec + c_msec + i_run_sec) mod 60
  - min_next = (min + c_sec + i_run_min) mod 60
  - hour_next = (hour + c_min + i_run_hour) mod 24
- Adjust pulses never generate a carry into the next field; 59 -> 0 via i_run_sec leaves min unchanged.
- Simultaneous natural carry and adjust on one field: the field advances by 2 with modulo wrap, e.g. sec 59 -> 1.
  - The natural carry out of that field is still issued, because carry depends only on the pre-update value.
- Concurrent pulses on several adjust inputs are each applied to their own field independently.
  - The control unit guarantees at most one pulse per cycle, but the datapath does not rely on that.
- Modulo arithmetic:
  - Compute sums in one extra bit, then subtract the modulus if sum >= N.
  - The maximum sum is N+1, so one conditional subtract is sufficient.
- Adjust pulses do not reset the msec field or the tick counter; the time base is never disturbed.
- o_sec_tick is registered: 1 in the cycle after the edge where c_msec caused a sec change, otherwise 0.
  - Adjust steps do not assert it.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.
- Out-of-range register values cannot occur; no recovery logic required.

Test Plan (TICK_DIV=4, INIT_HOUR=12 unless stated):
- Reset then run 400 clk -> 100 ticks; o_msec wraps 99->0, o_sec=1, o_sec_tick high exactly one cycle; o_min=0, o_hour=12.
- Force sec=59, msec=99, pulse i_run_sec in the tick cycle -> o_sec=1, o_min=1, o_msec=0.
- With o_min=59, pulse i_run_min once -> o_min=0, o_hour unchanged at 12; o_sec_tick stays 0.
- Preset 23:59:59.99, wait one tick -> 00:00:00.00; o_hour=0; o_sec_tick pulse.
- Pulse i_run_sec, i_run_min and i_run_hour in the same cycle from 12:10:20 -> 13:11:21; msec and tick phase unchanged (next tick still lands on the original 4-cycle grid).
- Assert rst asynchronously mid-cycle at 05:30:45.50 -> outputs 12:00:00.00 before the next clk edge; counting resumes with first tick 4 cycles after release.
